melody_sequencer: RTL and testbench
===================================

# melody_sequencer

Parametrised score player that steps through a writable note memory at a programmable tempo and drives a note index to the tone generator. It replaces hard-coded melody tables, and it generates its step timing with clock enables on a single clock domain, not derived clocks. It adds load, start/stop/pause, loop/one-shot, tempo scaling and automatic articulation gaps. It sits between the control/keypad logic and the note-to-frequency/buzzer stage of the music design.

## Interface
- STEP_CYCLES, 3125000: clk cycles per score step at tempo 0 (50 MHz / 16 steps/s); must be ≥ 8.
- NOTE_W, 5: note index width; value 0 = rest.
- DEPTH, 128: score memory entries; power of two.
- ADDR_W, 7: log2(DEPTH).

Ports (name, direction, width, meaning):
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high; clears all state except score memory
- wr_en  in  1  score write strobe
- wr_addr  in  ADDR_W  score write address
- wr_data  in  NOTE_W  score write data
- last_addr  in  ADDR_W  final step of the score (inclusive)
- start  in  1  pulse; begin playback at address 0
- stop  in  1  pulse; abort playback, return to IDLE
- pause  in  1  pulse; toggle PLAY↔PAUSE
- loop  in  1  1 = wrap to 0 after last_addr, 0 = one-shot
- tempo  in  2  step period = STEP_CYCLES >> tempo
- artic_en  in  1  mute final quarter of each step
- note_index  out  NOTE_W  current note to tone stage (0 = silent)
- step_addr  out  ADDR_W  address being played
- playing  out  1  state is PLAY
- paused  out  1  state is PAUSE
- done  out  1  one-cycle pulse at end of a one-shot run
- wrap  out  1  one-cycle pulse when a loop wraps to 0

## Operation
- States: IDLE, PLAY, PAUSE. All outputs reset to 0. Reset enters IDLE with step_addr = 0 and the prescaler at 0.
- Command priority in one cycle: reset > stop > start > pause.
- IDLE:
  - start → PLAY, step_addr = 0, prescaler = 0.
  - pause is ignored.
  - note_index = 0.
- PLAY:
  - The prescaler counts 0..limit, where limit = (STEP_CYCLES >> tempo) − 1.
  - Step tick: prescaler ≥ limit. On a tick the prescaler returns to 0.
  - Tick with step_addr ≠ last_addr: step_addr increments.
  - Tick with step_addr == last_addr and loop = 1: step_addr = 0, wrap pulses.
  - Tick with step_addr == last_addr and loop = 0: go to IDLE, step_addr = 0, done pulses.
- PAUSE:
  - The prescaler and step_addr hold, and note_index = 0.
  - A pause pulse returns to PLAY at the held position.
  - start restarts from 0 in PLAY.
- stop: from PLAY or PAUSE → IDLE, step_addr = 0, no done pulse.
- start while in PLAY restarts from address 0 with the prescaler cleared.
- Score memory: DEPTH × NOTE_W, synchronous write. Contents are undefined after power-up and are not cleared by reset.
  - A write is accepted in any state.
  - A read and write to the same address in the same cycle returns the old data.
- Articulation: when artic_en = 1 and in PLAY, note_index is forced to 0 while prescaler ≥ limit − (limit >> 2).
- The loop and last_addr inputs are sampled at each tick.
  - If last_addr is lowered below step_addr, playback continues to DEPTH−1, wraps naturally to 0, and then honours last_addr.
  - last_addr = 0 plays a single step.
- A tempo change takes effect immediately. If the prescaler is already ≥ the new limit, the tick occurs on the next cycle.

## Timing
- Start pulse in cycle t: PLAY and step_addr = 0 at t+1.
- note_index = mem[step_addr] is registered from the memory read: it shows mem[0] at t+2, and on each address change it updates one cycle after step_addr.
- Step length is exactly limit+1 clk cycles. The first step after start is the same length.
- The done and wrap pulses are asserted in the cycle after the tick, coincident with the new step_addr.
- playing/paused are registered and change in the cycle after the command.
- Muting on articulation, PAUSE, IDLE and stop is registered. It takes effect with the same one-cycle latency as note_index.

## Test plan
- Bench parameters for all scenarios: STEP_CYCLES = 8, DEPTH = 8, ADDR_W = 3.
- Reset mid-playback at step 3 → the next cycle shows all outputs 0 and state IDLE, and memory is unchanged (replay gives the same notes).
- Load mem = {29, 27, 28, 0, 13, 14, 15, 25}, last_addr = 3, loop = 0, start → note_index 29, 27, 28, 0, each held 8 cycles. done pulses once, step_addr returns to 0, note_index = 0.
- Same score with loop = 1, last_addr = 1 → sequence 29, 27, 29, 27… A wrap pulse occurs every 16 cycles, with no done.
- pause after 3 cycles of step 2, hold 20 cycles, then pause again → note 0 while paused. Step 2 then resumes with 5 cycles remaining.
- tempo 0→1 mid-step with prescaler = 5 → tick on the next cycle, after which steps are 4 cycles long.
- artic_en = 1, tempo = 0 (limit = 7, threshold 6) → the note is present for prescaler values 0–5 and 0 for 6–7 of every step.
- Simultaneous start+stop in PLAY → IDLE.
- Write to addr 2 during step 1 → the new value plays at step 2.

Source files
------------

// File: rtl/melody_sequencer.sv
// Score player: steps through a writable note memory at a programmable tempo
// and drives the current note index to the tone stage, using one clock domain.
module melody_sequencer #(
  parameter int STEP_CYCLES = 3125000,
  parameter int NOTE_W      = 5,
  parameter int DEPTH       = 128,
  parameter int ADDR_W      = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [NOTE_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop,
  input  logic [1:0]        tempo,
  input  logic              artic_en,
  output logic [NOTE_W-1:0] note_index,
  output logic [ADDR_W-1:0] step_addr,
  output logic              playing,
  output logic              paused,
  output logic              done,
  output logic              wrap
);

  localparam int PW = $clog2(STEP_CYCLES + 1);
  localparam logic [PW-1:0] STEP_P = PW'(STEP_CYCLES);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

  state_t            state, state_n;
  logic [PW-1:0]     presc, presc_n;
  logic [ADDR_W-1:0] addr_n;
  logic [NOTE_W-1:0] note_n;
  logic              done_n, wrap_n;
  logic [PW-1:0]     limit, thr;
  logic              tick;
  logic [NOTE_W-1:0] mem [DEPTH];

  // Score memory is never reset; a same-cycle read sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign limit = (STEP_P >> tempo) - PW'(1);
  assign thr   = limit - (limit >> 2);
  assign tick  = (state == PLAY) && (presc >= limit);

  always_comb begin
    state_n = state;
    presc_n = presc;
    addr_n  = step_addr;
    done_n  = 1'b0;
    wrap_n  = 1'b0;
    if (stop) begin
      state_n = IDLE;
      presc_n = '0;
      addr_n  = '0;
    end else if (start) begin
      state_n = PLAY;
      presc_n = '0;
      addr_n  = '0;
    end else begin
      case (state)
        PLAY: begin
          if (pause) begin
            state_n = PAUSE;
          end else if (tick) begin
            presc_n = '0;
            if (step_addr != last_addr) begin
              addr_n = step_addr + ADDR_W'(1);
            end else if (loop) begin
              addr_n = '0;
              wrap_n = 1'b1;
            end else begin
              addr_n  = '0;
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end else begin
            presc_n = presc + PW'(1);
          end
        end
        PAUSE: begin
          if (pause) state_n = PLAY;
        end
        default: ;
      endcase
    end
    // Mute decision uses the same cycle's position so it lines up with the note.
    note_n = '0;
    if (state == PLAY && !(artic_en && presc >= thr)) note_n = mem[step_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      presc      <= '0;
      step_addr  <= '0;
      note_index <= '0;
      playing    <= 1'b0;
      paused     <= 1'b0;
      done       <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      state      <= state_n;
      presc      <= presc_n;
      step_addr  <= addr_n;
      note_index <= note_n;
      playing    <= (state_n == PLAY);
      paused     <= (state_n == PAUSE);
      done       <= done_n;
      wrap       <= wrap_n;
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: directed scenarios plus random
// traffic, compared each cycle against a step/elapsed-time reference model.
module tb_melody_sequencer;

  localparam int NW = 5;
  localparam int AW = 3;
  localparam int SC = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0, wr_en = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic          loop = 1'b0, artic_en = 1'b0;
  logic [AW-1:0] wr_addr = '0, last_addr = '0;
  logic [NW-1:0] wr_data = '0;
  logic [1:0]    tempo = '0;
  logic [NW-1:0] note_index;
  logic [AW-1:0] step_addr;
  logic          playing, paused, done, wrap;

  melody_sequencer #(.STEP_CYCLES(SC), .NOTE_W(NW), .DEPTH(8), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .last_addr(last_addr), .start(start), .stop(stop), .pause(pause), .loop(loop),
    .tempo(tempo), .artic_en(artic_en), .note_index(note_index), .step_addr(step_addr),
    .playing(playing), .paused(paused), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cnt_done = 0;
  int cnt_wrap = 0;

  // Reference model: mode 0 idle, 1 play, 2 pause; elapsed = cycles spent in current step.
  int          m_mode = 0, m_pos = 0, m_el = 0;
  logic [NW-1:0] m_mem [8];
  logic [NW-1:0] m_note = '0;
  bit          m_done = 1'b0, m_wrap = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    int period, gap_at, nmode, npos, nel;
    bit ntick, nd, nw;
    logic [NW-1:0] nnote;
    period = SC >> tempo;
    gap_at = (period - 1) - (period - 1) / 4;
    ntick  = (m_mode == 1) && (m_el >= period - 1);
    nnote  = '0;
    if (m_mode == 1 && !(artic_en && m_el >= gap_at)) nnote = m_mem[m_pos];
    nmode = m_mode; npos = m_pos; nel = m_el; nd = 1'b0; nw = 1'b0;
    if (reset) begin
      nmode = 0; npos = 0; nel = 0; nnote = '0;
    end else if (stop) begin
      nmode = 0; npos = 0; nel = 0;
    end else if (start) begin
      nmode = 1; npos = 0; nel = 0;
    end else if (m_mode == 1 && pause) begin
      nmode = 2;
    end else if (m_mode == 2 && pause) begin
      nmode = 1;
    end else if (ntick) begin
      nel = 0;
      if (m_pos != int'(last_addr)) npos = (m_pos + 1) % 8;
      else if (loop) begin npos = 0; nw = 1'b1; end
      else begin npos = 0; nmode = 0; nd = 1'b1; end
    end else if (m_mode == 1) begin
      nel = m_el + 1;
    end
    if (wr_en) m_mem[wr_addr] = wr_data;
    @(posedge clk);
    #1;
    m_mode = nmode; m_pos = npos; m_el = nel; m_note = nnote; m_done = nd; m_wrap = nw;
    chk("note_index", 32'(note_index), 32'(m_note));
    chk("ctrl{addr,play,pause,done,wrap}", {27'd0, step_addr, playing, paused, done, wrap},
        {27'd0, 3'(m_pos), m_mode == 1, m_mode == 2, m_done, m_wrap});
    cnt_done += int'(done);
    cnt_wrap += int'(wrap);
    reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; wr_en = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write(input int a, input int d);
    wr_en = 1'b1; wr_addr = 3'(a); wr_data = 5'(d);
    step();
  endtask

  initial begin
    int score [8];
    score = '{29, 27, 28, 0, 13, 14, 15, 25};

    reset = 1'b1; step();
    reset = 1'b1; step();
    chk("reset_outputs", {note_index, step_addr, playing, paused, done, wrap}, 0);
    for (int i = 0; i < 8; i++) write(i, score[i]);

    // One-shot, four steps
    last_addr = 3'd3; loop = 1'b0; tempo = 2'd0;
    cnt_done = 0;
    start = 1'b1; step();
    step();
    chk("first_note", 32'(note_index), 29);
    run(38);
    chk("oneshot_done_count", cnt_done, 1);
    chk("oneshot_end_note", 32'(note_index), 0);

    // Looping over two steps
    last_addr = 3'd1; loop = 1'b1; cnt_wrap = 0; cnt_done = 0;
    start = 1'b1; step();
    run(40);
    chk("loop_wrap_count", cnt_wrap, 2);
    chk("loop_done_count", cnt_done, 0);
    stop = 1'b1; step();
    chk("stop_idle", {30'd0, playing, paused}, 0);

    // Reset in the middle of step 3, then replay from memory
    last_addr = 3'd7; loop = 1'b0;
    start = 1'b1; step();
    run(26);
    chk("at_step3", 32'(step_addr), 3);
    reset = 1'b1; step();
    chk("midplay_reset", {note_index, step_addr, playing, paused, done, wrap}, 0);
    start = 1'b1; step();
    run(26);
    chk("replay_note3", 32'(note_index), 0);
    run(8);
    chk("replay_note4", 32'(note_index), 13);

    // Pause 3 cycles into step 2, hold 20 cycles, resume
    start = 1'b1; step();
    run(19);
    pause = 1'b1; step();
    run(20);
    chk("paused_flag", 32'(paused), 1);
    chk("paused_mute", 32'(note_index), 0);
    pause = 1'b1; step();
    run(4);
    chk("resume_still_step2", 32'(step_addr), 2);
    step();
    chk("resume_step3", 32'(step_addr), 3);

    // Tempo change when prescaler is already past the new limit
    start = 1'b1; step();
    run(5);
    tempo = 2'd1; step();
    chk("tempo_early_tick", 32'(step_addr), 1);
    run(3);
    chk("tempo_short_hold", 32'(step_addr), 1);
    step();
    chk("tempo_short_step", 32'(step_addr), 2);
    tempo = 2'd0;

    // Articulation gap in the last quarter of each step
    artic_en = 1'b1;
    start = 1'b1; step();
    run(6);
    chk("artic_on", 32'(note_index), 29);
    step();
    chk("artic_gap", 32'(note_index), 0);
    run(2);
    chk("artic_next", 32'(note_index), 27);
    artic_en = 1'b0;

    // start and stop together while playing
    start = 1'b1; stop = 1'b1; step();
    chk("start_stop_idle", 32'(playing), 0);

    // Rewrite step 2 while step 1 plays
    start = 1'b1; step();
    run(9);
    write(2, 7);
    run(8);
    chk("live_write", 32'(note_index), 7);
    stop = 1'b1; step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 8) start = 1'b1;
      else if (r < 12) stop = 1'b1;
      else if (r < 20) pause = 1'b1;
      else if (r < 22) reset = 1'b1;
      if ($urandom_range(0, 99) < 3) tempo = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 2) loop = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 2) artic_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 2) last_addr = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 5) begin
        wr_en = 1'b1; wr_addr = 3'($urandom_range(0, 7)); wr_data = 5'($urandom_range(0, 31));
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
